// File: rtl/ahb_pack.sv
// ============================================================================
// ahb_pack : shared AHB transfer enums and burst-length constants
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_pack;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } t_htrans;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } t_hburst;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } t_hresp;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HALF  = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } t_hsize;

   localparam int INCR4  = 4;
   localparam int INCR8  = 8;
   localparam int INCR16 = 16;

   function automatic logic is_fixed_incr(input logic [2:0] burst);
      return (burst == HBURST_INCR4) || (burst == HBURST_INCR8) ||
             (burst == HBURST_INCR16);
   endfunction

   // Number of SEQ beats that follow the NONSEQ of a fixed INCR burst.
   function automatic logic [3:0] burst_seq_beats(input logic [2:0] burst);
      case (burst)
         HBURST_INCR4:  return 4'(INCR4 - 1);
         HBURST_INCR8:  return 4'(INCR8 - 1);
         HBURST_INCR16: return 4'(INCR16 - 1);
         default:       return 4'd0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_pick.sv
// ============================================================================
// ahb_rr_pick : rotate-priority picker, searches ptr+1 .. ptr (ptr last)
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_rr_pick #(
   parameter int NUM_MGR = 4,
   parameter int MW      = 2
) (
   input  logic [NUM_MGR-1:0] req,
   input  logic [MW-1:0]      ptr,
   output logic [NUM_MGR-1:0] gnt,
   output logic               valid
);

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int i = 1; i <= NUM_MGR; i++) begin
         if (!valid && req[(int'(ptr) + i) % NUM_MGR]) begin
            gnt[(int'(ptr) + i) % NUM_MGR] = 1'b1;
            valid                          = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
// ahb_bus_arbiter : round-robin AHB arbiter with fixed-burst locking.
// Optional SPLIT masking enabled by defining AHB_ARB_SPLIT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ahb_bus_arbiter
   import ahb_pack::*;
#(
   parameter  int NUM_MGR     = 4,
   parameter  int DEFAULT_MGR = 0,
   localparam int MW          = $clog2(NUM_MGR)
) (
   input  logic               i_hclk,
   input  logic               i_hreset_n,
   input  logic [NUM_MGR-1:0] i_hbusreq,
   input  logic [1:0]         i_htrans,
   input  logic [2:0]         i_hburst,
   input  logic               i_hready,
   input  logic [1:0]         i_hresp,
   input  logic [NUM_MGR-1:0] i_hsplit,
   output logic [NUM_MGR-1:0] o_hgrant,
   output logic [MW-1:0]      o_hmaster,
   output logic [MW-1:0]      o_hmaster_data
);

   typedef enum logic [0:0] {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } t_state;

   localparam logic [NUM_MGR-1:0] DEF_ONEHOT = NUM_MGR'(1) << DEFAULT_MGR;
   localparam logic [MW-1:0]      DEF_IDX    = MW'(DEFAULT_MGR);

   t_state             state, state_n;
   logic [3:0]         cnt, cnt_n;
   logic [MW-1:0]      ptr;
   logic [NUM_MGR-1:0] split_mask;
   logic [NUM_MGR-1:0] pick_gnt, win;
   logic               pick_valid, arb_edge;
   logic [MW-1:0]      pick_idx, grant_idx;

`ifdef AHB_ARB_SPLIT_EN
   logic [NUM_MGR-1:0] split_set;

   always_comb begin
      split_set = '0;
      if (!i_hready && i_hresp == HRESP_SPLIT)
         split_set[o_hmaster_data] = 1'b1;
   end

   // A release pulse and a new SPLIT on the same bit leave the bit set.
   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n)
         split_mask <= '0;
      else
         split_mask <= (split_mask & ~i_hsplit) | split_set;
   end
`else
   logic unused_hsplit;
   assign split_mask    = '0;
   assign unused_hsplit = &{1'b0, i_hsplit};
`endif

   ahb_rr_pick #(
      .NUM_MGR (NUM_MGR),
      .MW      (MW)
   ) u_pick (
      .req   (i_hbusreq & ~split_mask),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx  = DEF_IDX;
      grant_idx = DEF_IDX;
      for (int k = 0; k < NUM_MGR; k++) begin
         if (pick_gnt[k]) pick_idx  = MW'(k);
         if (o_hgrant[k]) grant_idx = MW'(k);
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      arb_edge = 1'b0;
      win      = '0;
      if (pick_valid)
         win = pick_gnt;
      else if (!split_mask[DEFAULT_MGR])
         win = DEF_ONEHOT;
      case (state)
         ST_OPEN: begin
            if (i_hready && i_htrans == HTRANS_NONSEQ && is_fixed_incr(i_hburst)) begin
               state_n = ST_LOCKED;
               cnt_n   = burst_seq_beats(i_hburst);
            end else if (i_hready) begin
               arb_edge = 1'b1;
            end
         end
         ST_LOCKED: begin
            // Abort on the first (wait) cycle of a two-cycle response.
            if (!i_hready && i_hresp != HRESP_OKAY) begin
               state_n = ST_OPEN;
               cnt_n   = 4'd0;
            end else if (i_hready && i_htrans == HTRANS_SEQ) begin
               cnt_n = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_n  = ST_OPEN;
                  arb_edge = 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_OPEN;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_hclk or negedge i_hreset_n) begin
      if (!i_hreset_n) begin
         state          <= ST_OPEN;
         cnt            <= 4'd0;
         ptr            <= DEF_IDX;
         o_hgrant       <= DEF_ONEHOT;
         o_hmaster      <= DEF_IDX;
         o_hmaster_data <= DEF_IDX;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (arb_edge) begin
            o_hgrant <= win;
            if (pick_valid)
               ptr <= pick_idx;
         end
         if (i_hready) begin
            o_hmaster      <= grant_idx;
            o_hmaster_data <= o_hmaster;
         end
      end
   end

endmodule

`default_nettype wire
